// File: rtl/spi_reg_ctrl.sv
// SPI register transaction controller: turns byte frames from the SPI slave engine into register bus reads/writes.
// Optional: define SPI_REG_STATUS_EN to shift out {err_ro, frame_active, tx_cnt[5:0]} during the CMD byte.
module spi_reg_ctrl #(
    parameter int AW      = 6,
    parameter int RO_BASE = 48
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ncs_s,
    input  logic [7:0]    rx_data,
    input  logic          rx_done,
    input  logic          tx_done,
    output logic [7:0]    tx_data,
    output logic          tx_call,
    output logic [AW-1:0] reg_addr,
    output logic [7:0]    reg_wdata,
    output logic          reg_we,
    input  logic [7:0]    reg_rdata,
    output logic          frame_active,
    output logic          err_ro
);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WR,
        RD_FETCH,
        RD_LOAD,
        RD
    } state_t;

    localparam logic [AW:0] RO_LIM = (AW+1)'(RO_BASE);

    state_t        state_q;
    logic [AW-1:0] addr_q;
    logic [7:0]    tx_data_q;
    logic          tx_call_q;
    logic [AW-1:0] reg_addr_q;
    logic [7:0]    reg_wdata_q;
    logic          reg_we_q;
    logic          frame_active_q;
    logic          err_ro_q;

    logic [AW-1:0] addr_inc_d;
    logic          wr_ok_d;
    logic [7:0]    cmd_tx_d;

    assign addr_inc_d = addr_q + AW'(1);
    assign wr_ok_d    = ({1'b0, addr_q} < RO_LIM);

`ifdef SPI_REG_STATUS_EN
    logic [5:0] tx_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_cnt_q <= 6'd0;
        end else if (tx_done) begin
            tx_cnt_q <= tx_cnt_q + 6'd1;
        end
    end

    // frame_active is about to become 1 as the CMD byte is loaded
    assign cmd_tx_d = {err_ro_q, 1'b1, tx_cnt_q};
`else
    assign cmd_tx_d = 8'h00;
`endif

    logic unused_ok;
    assign unused_ok = &{1'b0, rx_data[6:AW], tx_done};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            tx_data_q      <= 8'h00;
            tx_call_q      <= 1'b0;
            reg_addr_q     <= '0;
            reg_wdata_q    <= 8'h00;
            reg_we_q       <= 1'b0;
            frame_active_q <= 1'b0;
            err_ro_q       <= 1'b0;
        end else begin
            reg_we_q <= 1'b0;
            // Chip select release ends the frame and beats any coincident byte
            if (state_q != IDLE && ncs_s) begin
                state_q        <= IDLE;
                tx_call_q      <= 1'b0;
                frame_active_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (!ncs_s) begin
                            state_q        <= CMD;
                            tx_data_q      <= cmd_tx_d;
                            tx_call_q      <= 1'b1;
                            frame_active_q <= 1'b1;
                        end
                    end
                    CMD: begin
                        if (rx_done) begin
                            addr_q  <= rx_data[AW-1:0];
                            state_q <= rx_data[7] ? RD_FETCH : WR;
                        end
                    end
                    WR: begin
                        if (rx_done) begin
                            if (wr_ok_d) begin
                                reg_we_q    <= 1'b1;
                                reg_addr_q  <= addr_q;
                                reg_wdata_q <= rx_data;
                                if (addr_q == '0 && rx_data == 8'h01) begin
                                    err_ro_q <= 1'b0;
                                end
                            end else begin
                                err_ro_q <= 1'b1;
                            end
                            addr_q <= addr_inc_d;
                        end
                    end
                    RD_FETCH: begin
                        reg_addr_q <= addr_q;
                        state_q    <= RD_LOAD;
                    end
                    RD_LOAD: begin
                        tx_data_q <= reg_rdata;
                        addr_q    <= addr_inc_d;
                        state_q   <= RD;
                    end
                    RD: begin
                        if (rx_done) begin
                            state_q <= RD_FETCH;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign tx_data      = tx_data_q;
    assign tx_call      = tx_call_q;
    assign reg_addr     = reg_addr_q;
    assign reg_wdata    = reg_wdata_q;
    assign reg_we       = reg_we_q;
    assign frame_active = frame_active_q;
    assign err_ro       = err_ro_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed testbench for spi_reg_ctrl: write/read frames, read-only protection, aborts and reset.
module tb_spi_reg_ctrl;

    logic       clk;
    logic       rst_n;
    logic       ncs_s;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       tx_done;
    logic [7:0] tx_data;
    logic       tx_call;
    logic [5:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic [7:0] reg_rdata;
    logic       frame_active;
    logic       err_ro;

    logic [7:0] regsMem [0:63];
    int checkCount;
    int passCount;

    spi_reg_ctrl #(.AW(6), .RO_BASE(48)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ncs_s        (ncs_s),
        .rx_data      (rx_data),
        .rx_done      (rx_done),
        .tx_done      (tx_done),
        .tx_data      (tx_data),
        .tx_call      (tx_call),
        .reg_addr     (reg_addr),
        .reg_wdata    (reg_wdata),
        .reg_we       (reg_we),
        .reg_rdata    (reg_rdata),
        .frame_active (frame_active),
        .err_ro       (err_ro)
    );

    assign reg_rdata = regsMem[reg_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic startFrame();
        @(negedge clk);
        ncs_s = 1'b0;
        @(negedge clk);
    endtask

    task automatic endFrame();
        @(negedge clk);
        ncs_s = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulseTxDone();
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        for (int i = 0; i < 64; i++) regsMem[i] = 8'(i);
        regsMem[6'h3E] = 8'h11;
        regsMem[6'h3F] = 8'h22;
        regsMem[6'h00] = 8'h5A;
        rst_n   = 1'b0;
        ncs_s   = 1'b1;
        rx_data = 8'h00;
        rx_done = 1'b0;
        tx_done = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_tx_call", 32'(tx_call), 32'h0);
        checkOutput("rst_frame_active", 32'(frame_active), 32'h0);
        checkOutput("rst_err_ro", 32'(err_ro), 32'h0);
        checkOutput("rst_tx_data", 32'(tx_data), 32'h00);
        rst_n = 1'b1;

        // Write frame 0x05, 0xAA, 0xBB
        startFrame();
        checkOutput("cmd_frame_active", 32'(frame_active), 32'h1);
        checkOutput("cmd_tx_call", 32'(tx_call), 32'h1);
`ifdef SPI_REG_STATUS_EN
        checkOutput("cmd_tx_data", 32'(tx_data), 32'h40);
`else
        checkOutput("cmd_tx_data", 32'(tx_data), 32'h00);
`endif
        applyStimulus(8'h05);
        checkOutput("cmd_no_we", 32'(reg_we), 32'h0);
        applyStimulus(8'hAA);
        checkOutput("wr1_we", 32'(reg_we), 32'h1);
        checkOutput("wr1_addr", 32'(reg_addr), 32'h05);
        checkOutput("wr1_data", 32'(reg_wdata), 32'hAA);
        @(negedge clk);
        checkOutput("wr1_we_one_clk", 32'(reg_we), 32'h0);
        applyStimulus(8'hBB);
        checkOutput("wr2_we", 32'(reg_we), 32'h1);
        checkOutput("wr2_addr", 32'(reg_addr), 32'h06);
        checkOutput("wr2_data", 32'(reg_wdata), 32'hBB);
        checkOutput("wr_err_ro", 32'(err_ro), 32'h0);

        // Asynchronous reset in the middle of the write frame
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_we", 32'(reg_we), 32'h0);
        checkOutput("mid_rst_addr", 32'(reg_addr), 32'h00);
        checkOutput("mid_rst_wdata", 32'(reg_wdata), 32'h00);
        checkOutput("mid_rst_tx_call", 32'(tx_call), 32'h0);
        checkOutput("mid_rst_frame_active", 32'(frame_active), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        ncs_s = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_idle", 32'(frame_active), 32'h0);

        // Read frame starting at 0x3E, wrapping to 0x00
        startFrame();
        applyStimulus(8'hBE);
        @(negedge clk);
        @(negedge clk);
        checkOutput("rd1_tx_data", 32'(tx_data), 32'h11);
        applyStimulus(8'h00);
        @(negedge clk);
        @(negedge clk);
        checkOutput("rd2_tx_data", 32'(tx_data), 32'h22);
        applyStimulus(8'h00);
        @(negedge clk);
        checkOutput("rd3_wrap_addr", 32'(reg_addr), 32'h00);
        @(negedge clk);
        checkOutput("rd3_tx_data", 32'(tx_data), 32'h5A);
        checkOutput("rd_no_we", 32'(reg_we), 32'h0);
        endFrame();
        checkOutput("rd_end_frame_active", 32'(frame_active), 32'h0);

        // Write to read-only space, then clear the flag via the control register
        startFrame();
        applyStimulus(8'h31);
        applyStimulus(8'h55);
        checkOutput("ro_no_we", 32'(reg_we), 32'h0);
        checkOutput("ro_err_set", 32'(err_ro), 32'h1);
        endFrame();
        checkOutput("ro_err_sticky", 32'(err_ro), 32'h1);
        startFrame();
        applyStimulus(8'h00);
        applyStimulus(8'h01);
        checkOutput("clr_we", 32'(reg_we), 32'h1);
        checkOutput("clr_addr", 32'(reg_addr), 32'h00);
        checkOutput("clr_data", 32'(reg_wdata), 32'h01);
        checkOutput("clr_err_ro", 32'(err_ro), 32'h0);
        endFrame();

        // Frame aborted 3 bits into a write data byte
        startFrame();
        applyStimulus(8'h07);
        repeat (3) @(negedge clk);
        ncs_s = 1'b1;
        @(negedge clk);
        checkOutput("abort_frame_active", 32'(frame_active), 32'h0);
        checkOutput("abort_tx_call", 32'(tx_call), 32'h0);
        checkOutput("abort_no_we", 32'(reg_we), 32'h0);

        // rx_done coinciding with chip select release is discarded
        startFrame();
        applyStimulus(8'h07);
        @(negedge clk);
        ncs_s   = 1'b1;
        rx_data = 8'h99;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        checkOutput("coinc_no_we", 32'(reg_we), 32'h0);
        checkOutput("coinc_frame_active", 32'(frame_active), 32'h0);
        @(negedge clk);
        checkOutput("coinc_no_we_late", 32'(reg_we), 32'h0);

        // Status byte after 3 tx_done pulses with err_ro set
        startFrame();
        applyStimulus(8'h31);
        applyStimulus(8'h00);
        endFrame();
        pulseTxDone();
        pulseTxDone();
        pulseTxDone();
        startFrame();
`ifdef SPI_REG_STATUS_EN
        checkOutput("status_byte", 32'(tx_data), 32'hC3);
`else
        checkOutput("status_byte", 32'(tx_data), 32'h00);
`endif
        endFrame();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/spi_reg_ctrl.md
# spi_reg_ctrl

Transaction controller sitting above the SPI slave byte engine in the spider robot design. It parses byte frames from the engine into register read/write commands, drives the robot register bus (servo setpoints, mode flags), and preloads the engine's transmit byte so the SPI master can read registers back in the same frame. One instance per SPI slave port.

## Interface

Parameters:
- AW, 6, register address width; register space is 2^AW bytes.
- RO_BASE, 48, first read-only address; writes to addresses >= RO_BASE are dropped and flagged.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ncs_s  in  1  synchronized chip select from the byte engine; 1 = frame inactive.
- rx_data  in  8  byte received from the engine, valid while rx_done = 1.
- rx_done  in  1  one-clock pulse per received byte.
- tx_done  in  1  one-clock pulse per transmitted byte; counted for status only.
- tx_data  out  8  byte presented to the engine for the next MISO byte.
- tx_call  out  1  transmit enable to the engine.
- reg_addr  out  AW  register bus address.
- reg_wdata  out  8  register write data.
- reg_we  out  1  one-clock register write strobe.
- reg_rdata  in  8  register read data; combinational from reg_addr, valid in the same cycle.
- frame_active  out  1  1 while a frame is being processed (state != IDLE).
- err_ro  out  1  sticky flag: write to a read-only address was dropped.

## Operation

- Frame format: first byte CMD; CMD[7] = 1 read, 0 write; CMD[AW-1:0] = start address; CMD[6:AW] ignored. Subsequent bytes: write data (write frame) or don't-care dummies (read frame).
- Address auto-increments after every data byte, wrapping from 2^AW-1 to 0.
- States:
  - IDLE: ncs_s = 1. tx_call = 0. On ncs_s = 0 -> CMD; tx_data <= status byte (see Configuration); tx_call = 1.
  - CMD: on rx_done: latch address; CMD[7] = 0 -> WR; CMD[7] = 1 -> RD_FETCH.
  - WR: on each rx_done: address < RO_BASE -> reg_we pulse with reg_wdata = rx_data; otherwise no strobe and err_ro <= 1. Address increments either way.
  - RD_FETCH: reg_addr = address; one cycle later -> RD_LOAD.
  - RD_LOAD: tx_data <= reg_rdata; address++; -> RD.
  - RD: on each rx_done -> RD_FETCH (streams the next byte).
- In any state except IDLE, ncs_s = 1 -> IDLE on the next clock; no reg_we is issued for a partial byte. A pending RD_FETCH/RD_LOAD is abandoned.
- A frame containing only CMD performs no register access.
- err_ro is cleared only by reset or by a write of 0x01 to address 0 (the control register; the write also reaches the register bus).
- tx_call = 1 in every state except IDLE.

## Timing

- Reset values: tx_data = 0x00, tx_call = 0, reg_addr = 0, reg_wdata = 0x00, reg_we = 0, frame_active = 0, err_ro = 0; state IDLE; address 0.
- Write latency: reg_we asserted in the clock after rx_done, for exactly 1 clock.
- Read latency: tx_data updated 2 clocks after the rx_done of CMD or of the previous data byte. The SPI master must leave at least 4 clk periods between the last SCK rising edge of a byte and the first SCK falling edge of the next byte.
- rx_done coinciding with ncs_s rising: ncs_s wins; the byte is discarded.
- reg_addr holds its last value outside RD_FETCH/WR strobes.

## Configuration

- SPI_REG_STATUS_EN defined: the byte shifted out during CMD is the status byte {err_ro, frame_active, tx_cnt[5:0]}. tx_cnt counts tx_done pulses since reset, modulo 64.
- Undefined: tx_data = 0x00 during CMD; tx_cnt logic is absent.

## Test plan

- Reset mid-frame (rst_n low while in WR): all outputs return to their reset values immediately; state IDLE.
- Write frame 0x05, 0xAA, 0xBB: reg_we pulses at address 5 with 0xAA, then at address 6 with 0xBB; err_ro stays 0.
- Read frame 0x80|0x3E with regs[0x3E] = 0x11 and regs[0x3F] = 0x22: tx_data = 0x11 within 2 clk of the CMD rx_done; after the next rx_done, tx_data = 0x22 and the address wraps to 0x00.
- Write frame 0x31, 0x55 with RO_BASE = 48: no reg_we; err_ro = 1. Then frame 0x00, 0x01: reg_we at address 0 with 0x01; err_ro = 0.
- ncs_s rises 3 SCK bits into a write data byte: no reg_we; frame_active = 0 one clock later.
- With SPI_REG_STATUS_EN after 3 tx_done pulses and err_ro = 1: the next frame's CMD-phase tx_data = 0xC3.
